// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and helpers for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Execute-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Memory-wait sequencer states
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        WAIT  = 2'b01,
        ERROR = 2'b10
    } state_t;

    // Pick the youngest in-flight producer of a source register; $0 is never forwarded
    function automatic fwd_sel_t fwdSel(
        input logic [4:0] src,
        input logic       weM,
        input logic [4:0] wrM,
        input logic       weW,
        input logic [4:0] wrW
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (src != 5'd0 && weM && wrM == src) begin
            sel = FWD_MEM;
        end else if (src != 5'd0 && weW && wrW == src) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating event counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count events, sticking at all-ones; clear beats increment
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Forwarding, stall and flush generation for the five-stage
//               pipeline, plus a memory-wait freeze sequencer with timeout
//               watchdog and saturating stall / wait performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWE,
    input  logic             RegWM,
    input  logic             RegWW,
    input  logic             MemToRegE,
    input  logic             MemToRegM,
    input  logic             BranchD,
    input  logic             MemAccessM,
    input  logic             MemReady,
    input  logic             clr_counts,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushE,
    output logic             flushW,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] wait_count
);

    localparam int TIMER_W = $clog2(MAX_WAIT + 1);
    localparam logic [TIMER_W-1:0] c_maxWait = TIMER_W'(MAX_WAIT);
    localparam logic [TIMER_W-1:0] c_one     = TIMER_W'(1);

    state_t             r_state;
    state_t             w_stateNext;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timerNext;
    logic               w_freeze;
    logic               w_lwStall;
    logic               w_branchStall;
    logic               w_hazStall;
    fwd_sel_t           w_fwdA;
    fwd_sel_t           w_fwdB;

    // Data hazards: forwarding selects and the two stall sources
    always_comb begin
        w_fwdA    = fwdSel(RsE, RegWM, WriteRegM, RegWW, WriteRegW);
        w_fwdB    = fwdSel(RtE, RegWM, WriteRegM, RegWW, WriteRegW);
        forwardAD = (RsD != 5'd0) && RegWM && (WriteRegM == RsD);
        forwardBD = (RtD != 5'd0) && RegWM && (WriteRegM == RtD);
        w_lwStall = MemToRegE && ((RtE == RsD) || (RtE == RtD));
        w_branchStall = BranchD &&
            ((RegWE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
             (MemToRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
        w_hazStall = w_lwStall || w_branchStall;
    end

    assign forwardAE = w_fwdA;
    assign forwardBE = w_fwdB;

    // Freeze holds every stage; a freeze suppresses the Execute bubble so the
    // instruction already in Execute is kept rather than discarded
    always_comb begin
        stallF = w_hazStall || w_freeze;
        stallD = w_hazStall || w_freeze;
        stallE = w_freeze;
        stallM = w_freeze;
        flushW = w_freeze;
        flushE = w_hazStall && !w_freeze;
    end

    // Memory-wait sequencer: state and consecutive-freeze timer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RUN;
            r_timer <= '0;
        end else begin
            r_state <= w_stateNext;
            r_timer <= w_timerNext;
        end
    end

    // Next-state and freeze decode; completion wins over the timeout check
    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        w_freeze    = 1'b0;
        case (r_state)
            RUN: begin
                w_freeze = MemAccessM && !MemReady;
                if (w_freeze) begin
                    w_stateNext = WAIT;
                    w_timerNext = c_one;
                end else begin
                    w_timerNext = '0;
                end
            end
            WAIT: begin
                w_freeze = MemAccessM && !MemReady;
                if (MemReady) begin
                    w_stateNext = RUN;
                    w_timerNext = '0;
                end else if (r_timer == c_maxWait) begin
                    w_stateNext = ERROR;
                end else begin
                    w_timerNext = r_timer + c_one;
                end
            end
            ERROR: begin
                w_freeze = 1'b1;
            end
            default: begin
                w_stateNext = RUN;
                w_timerNext = '0;
            end
        endcase
    end

    assign mem_timeout = (r_state == ERROR);

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hazStall && !w_freeze),
        .clr   (clr_counts),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_waitCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_freeze),
        .clr   (clr_counts),
        .count (wait_count)
    );

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and memory-wait controller for the five-stage MIPS datapath. It generates the forwarding selects, stalls and flushes that the datapath consumes (stallF, stallD, flushE, forwardAD/BD, forwardAE/BE). It also sequences multi-cycle data-memory accesses through MemReady by freezing the whole pipeline, with a timeout watchdog. It sits beside the datapath and the main control unit, and keeps saturating stall-cycle counters for performance debug.

## Interface
- MAX_WAIT, 16: consecutive memory-freeze cycles allowed before timeout (≥2).
- CNT_W, 16: width of each performance counter.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low (0 = reset); one clock, sampled on clk.
- RsD, RtD, RsE, RtE  in  5 each  source register fields, Decode/Execute.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
- RegWE, RegWM, RegWW  in  1 each  register-write enables per stage.
- MemToRegE, MemToRegM  in  1 each  load-in-stage flags.
- BranchD  in  1  branch in Decode (equality compare uses EQ1/EQ2).
- MemAccessM  in  1  load or store in Memory stage.
- MemReady  in  1  data memory completes the Memory-stage access this cycle.
- clr_counts  in  1  synchronous clear of both counters.
- stallF, stallD  out  1 each  hold PC / Decode register.
- stallE, stallM  out  1 each  hold Execute / Memory registers.
- flushE, flushW  out  1 each  bubble into Execute / WriteBack registers.
- forwardAD, forwardBD  out  1 each  Decode compare forward from ALUOutM.
- forwardAE, forwardBE  out  2 each  00 = register file, 01 = ResultW, 10 = ALUOutM.
- mem_timeout  out  1  sticky watchdog error.
- stall_count, wait_count  out  CNT_W each  hazard-stall / memory-freeze cycle counts.

## Operation
- Forwarding is combinational. forwardAE = 10 if RsE≠0 & RegWM & WriteRegM==RsE. Otherwise 01 if RsE≠0 & RegWW & WriteRegW==RsE. Otherwise 00. M beats W. forwardBE is the same using RtE.
- forwardAD = RsD≠0 & RegWM & WriteRegM==RsD. forwardBD uses RtD.
- lwstall = MemToRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & ((RegWE & WriteRegE∈{RsD,RtD}) | (MemToRegM & WriteRegM∈{RsD,RtD})).
- freeze: combinational, = MemAccessM & !MemReady in RUN/WAIT; constantly 1 in ERROR.
- stallF = stallD = lwstall | branchstall | freeze.
- stallE = stallM = flushW = freeze.
- flushE = (lwstall | branchstall) & !freeze. Freeze dominates, so Execute holds rather than bubbles.
- FSM states RUN, WAIT, ERROR; wait_timer counts consecutive freeze cycles.
  - RUN: on freeze, go to WAIT and set timer=1. Otherwise stay in RUN with timer=0.
  - WAIT: on MemReady, go to RUN and set timer=0. Else if timer==MAX_WAIT, go to ERROR. Else timer+1.
  - ERROR: terminal until reset; mem_timeout=1; full freeze held.
- stall_count increments on each cycle with (lwstall|branchstall) & !freeze.
- wait_count increments on each freeze cycle.
- Both counters saturate at 2^CNT_W−1. clr_counts wins over increment in the same cycle.

## Timing
- All forward/stall/flush outputs are same-cycle combinational from inputs and state. There are no combinational paths from counters.
- Memory access completes in the cycle MemReady=1. freeze drops in that cycle and the pipeline advances at the next edge.
- A zero-wait access (MemReady=1 on the first cycle) causes no freeze and no FSM transition.
- Timeout: with MemReady never asserted, freeze cycles 1..MAX_WAIT+1 occur in RUN/WAIT. mem_timeout rises on the following cycle.
- MemReady in the same cycle as timer==MAX_WAIT: completion wins, go to RUN.
- Reset values: state=RUN, timer=0, mem_timeout=0, both counts=0.
- All combinational outputs follow from inputs with no registered history beyond the state.
- Reset asserted mid-WAIT or in ERROR: RUN at the next edge; counters and timeout cleared.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - state_t enum (RUN, WAIT, ERROR).
- One sub-module, sat_counter (parameter W; inputs inc and clr), instantiated twice for stall_count and wait_count.

## Test plan
- Forwarding: RsE=5, WriteRegM=5, RegWM=1, WriteRegW=5, RegWW=1 -> forwardAE=10. Repeat with RsE=0 -> forwardAE=00.
- Load-use: MemToRegE=1, RtE=8, RsD=8 -> stallF=stallD=flushE=1 for one cycle, stall_count goes 0→1.
- Branch stall: BranchD=1, RegWE=1, WriteRegE=3, RtD=3 -> stallD=1 and flushE=1. Next cycle, with the producer in M (RegWM=1, WriteRegM=3) -> forwardBD=1, no stall.
- Memory wait: MemAccessM=1, MemReady low for 3 cycles then high -> 3 freeze cycles (all stall*=1, flushW=1, flushE=0), wait_count=3, back to RUN.
- Timeout: MAX_WAIT=4, MemReady held low -> mem_timeout=1 after 5 freeze cycles. Then reset=0 for one clock -> mem_timeout=0, counts=0, state RUN.
- Saturation/clear: CNT_W=2, 5 load-use stalls -> stall_count=3. clr_counts together with a stall -> stall_count=0.
